// File: rtl/fwd_hazard_scoreboard.sv
// Register scoreboard for NUNITS multi-cycle units: issue stalls (RAW/WAW/structural),
// writeback strobes and completing-unit forward selects. Optional macro: SCOREBOARD_FWD_EN.
module fwd_hazard_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NUNITS = 2,
    parameter int UNIT_W = 1,
    parameter int LAT_W  = 5,
    parameter int RIDX_W = 5
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iIssueValid,
    input  logic [UNIT_W-1:0]          iIssueUnit,
    input  logic [LAT_W-1:0]           iIssueLat,
    input  logic                       iIssueRdWr,
    input  logic [RIDX_W-1:0]          iIssueRd,
    input  logic                       iUseRs1,
    input  logic                       iUseRs2,
    input  logic [RIDX_W-1:0]          iRs1,
    input  logic [RIDX_W-1:0]          iRs2,
    input  logic                       iFlush,
    output logic                       oStall,
    output logic                       oIssueAccept,
    output logic [NUNITS-1:0]          oWbValid,
    output logic [NUNITS*RIDX_W-1:0]   oWbRd,
    output logic                       oFwdRs1Valid,
    output logic [UNIT_W-1:0]          oFwdRs1Unit,
    output logic                       oFwdRs2Valid,
    output logic [UNIT_W-1:0]          oFwdRs2Unit
);

    logic [LAT_W-1:0]  cnt_r [NUNITS];
    logic [RIDX_W-1:0] rd_r  [NUNITS];
    logic [NUNITS-1:0] wr_r;
    logic [NREGS-1:0]  pend_r;
    logic [UNIT_W-1:0] own_r [NREGS];

    logic [NUNITS-1:0] done_s;
    logic [NREGS-1:0]  clr_mask_s, set_mask_s, pend_nxt_s;
    logic [LAT_W-1:0]  lat_eff_s;
    logic              comp_rd_s, waw_s, struct_s, raw1_s, raw2_s, stall_s, accept_s;
    logic              fwd1_s, fwd2_s;
    logic              rs1_nz_s, rs2_nz_s;

    // A register is completing when its owning unit is in its writeback cycle.
    function automatic logic completing_f(input logic pend, input logic [UNIT_W-1:0] own,
                                          input logic [NUNITS-1:0] done);
        logic hit;
        hit = 1'b0;
        for (int u = 0; u < NUNITS; u++) begin
            if (own == UNIT_W'(u)) hit = done[u];
            else hit = hit;
        end
        return pend & hit;
    endfunction

    // Hazard detection, issue acceptance and next pending-register state.
    always_comb begin
        for (int u = 0; u < NUNITS; u++) done_s[u] = (cnt_r[u] == LAT_W'(1));
        rs1_nz_s  = (iRs1 != {RIDX_W{1'b0}});
        rs2_nz_s  = (iRs2 != {RIDX_W{1'b0}});
        comp_rd_s = completing_f(pend_r[iIssueRd], own_r[iIssueRd], done_s);
        waw_s     = iIssueRdWr & (iIssueRd != {RIDX_W{1'b0}}) & pend_r[iIssueRd] & ~comp_rd_s;
        struct_s  = 1'b0;
        for (int u = 0; u < NUNITS; u++) begin
            if (iIssueUnit == UNIT_W'(u)) struct_s = (cnt_r[u] > LAT_W'(1));
            else struct_s = struct_s;
        end
`ifdef SCOREBOARD_FWD_EN
        fwd1_s = iUseRs1 & rs1_nz_s & completing_f(pend_r[iRs1], own_r[iRs1], done_s);
        fwd2_s = iUseRs2 & rs2_nz_s & completing_f(pend_r[iRs2], own_r[iRs2], done_s);
`else
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
`endif
        raw1_s    = iUseRs1 & rs1_nz_s & pend_r[iRs1] & ~fwd1_s;
        raw2_s    = iUseRs2 & rs2_nz_s & pend_r[iRs2] & ~fwd2_s;
        stall_s   = raw1_s | raw2_s | (iIssueValid & (waw_s | struct_s));
        accept_s  = iIssueValid & ~stall_s & ~iFlush;
        lat_eff_s = (iIssueLat == {LAT_W{1'b0}}) ? LAT_W'(1) : iIssueLat;

        // Writeback clears only when the unit still owns the register; a same-cycle set wins.
        clr_mask_s = {NREGS{1'b0}};
        for (int u = 0; u < NUNITS; u++) begin
            clr_mask_s[rd_r[u]] = clr_mask_s[rd_r[u]] |
                                  (done_s[u] & wr_r[u] & (own_r[rd_r[u]] == UNIT_W'(u)));
        end
        set_mask_s           = {NREGS{1'b0}};
        set_mask_s[iIssueRd] = accept_s & iIssueRdWr;
        pend_nxt_s           = iFlush ? {NREGS{1'b0}} : ((pend_r & ~clr_mask_s) | set_mask_s);
        pend_nxt_s[0]        = 1'b0;
    end

    // Output drive; everything reads as zero while reset is asserted.
    always_comb begin
        oStall       = stall_s & ~iRST;
        oIssueAccept = accept_s & ~iRST;
        oWbValid     = done_s & {NUNITS{~iFlush & ~iRST}};
        oWbRd        = {(NUNITS*RIDX_W){1'b0}};
        for (int u = 0; u < NUNITS; u++) begin
            oWbRd[u*RIDX_W +: RIDX_W] = iRST ? {RIDX_W{1'b0}} : rd_r[u];
        end
        oFwdRs1Valid = fwd1_s & ~iRST;
        oFwdRs2Valid = fwd2_s & ~iRST;
        oFwdRs1Unit  = oFwdRs1Valid ? own_r[iRs1] : {UNIT_W{1'b0}};
        oFwdRs2Unit  = oFwdRs2Valid ? own_r[iRs2] : {UNIT_W{1'b0}};
    end

    // Unit countdown, destination latch and register ownership.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int u = 0; u < NUNITS; u++) begin
                cnt_r[u] <= {LAT_W{1'b0}};
                rd_r[u]  <= {RIDX_W{1'b0}};
            end
            wr_r   <= {NUNITS{1'b0}};
            pend_r <= {NREGS{1'b0}};
            for (int r = 0; r < NREGS; r++) own_r[r] <= {UNIT_W{1'b0}};
        end else begin
            for (int u = 0; u < NUNITS; u++) begin
                if (accept_s && (iIssueUnit == UNIT_W'(u))) begin
                    cnt_r[u] <= lat_eff_s;
                    rd_r[u]  <= iIssueRd;
                    wr_r[u]  <= iIssueRdWr;
                end else if (iFlush) begin
                    cnt_r[u] <= {LAT_W{1'b0}};
                end else if (cnt_r[u] != {LAT_W{1'b0}}) begin
                    cnt_r[u] <= cnt_r[u] - LAT_W'(1);
                end
            end
            pend_r <= pend_nxt_s;
            for (int r = 0; r < NREGS; r++) begin
                if (set_mask_s[r]) own_r[r] <= iIssueUnit;
            end
        end
    end

endmodule
